// File: rtl/mem_access_stage.sv
// Load/store memory access stage: runs one req/ack bus transaction per operation,
// builds store byte lanes, extends load data and reports access faults as a pulse.
module mem_access_stage #(
  parameter int XLEN        = 32,
  parameter int REG_SEL_W   = 5,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic                 iClk,
  input  logic                 iRst,
  input  logic                 iMemValid,
  input  logic                 iMemRead,
  input  logic                 iMemWrite,
  input  logic [XLEN-1:0]      iMemAddr,
  input  logic [XLEN-1:0]      iMemData,
  input  logic [2:0]           iMemOpType,
  input  logic [REG_SEL_W-1:0] iMemRdAddr,
  output logic                 oReady,
  output logic                 oBusReq,
  output logic                 oBusWe,
  output logic [XLEN-1:0]      oBusAddr,
  output logic [XLEN-1:0]      oBusWData,
  output logic [XLEN/8-1:0]    oBusBe,
  input  logic                 iBusAck,
  input  logic [XLEN-1:0]      iBusRData,
  output logic                 oRegDv,
  output logic [REG_SEL_W-1:0] oRegAddr,
  output logic [XLEN-1:0]      oRegData,
  output logic                 oExcDv,
  output logic [1:0]           oExcCause,
  output logic [XLEN-1:0]      oExcAddr
);

  generate
    if (XLEN != 32) begin : gBadXlen
      $error("mem_access_stage supports XLEN = 32 only");
    end
  endgenerate

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUS  = 2'd1;
  localparam logic [1:0] WB   = 2'd2;
  localparam int CNT_W = (ACK_TIMEOUT > 0) ? $clog2(ACK_TIMEOUT + 1) : 1;

  logic [1:0]           stateReg;
  logic [CNT_W-1:0]     cntReg;
  logic [CNT_W:0]       cntInc;
  logic [XLEN-1:0]      addrReg;
  logic [2:0]           opReg;
  logic [REG_SEL_W-1:0] rdReg;
  logic                 busReqReg, busWeReg, regDvReg, excDvReg;
  logic [XLEN-1:0]      busAddrReg, busWDataReg, regDataReg, excAddrReg;
  logic [XLEN/8-1:0]    busBeReg;
  logic [REG_SEL_W-1:0] regAddrReg;
  logic [1:0]           excCauseReg;

  logic                 accept, opLegal, misaligned, timeoutHit;
  logic [XLEN-1:0]      storeWData, loadExt;
  logic [3:0]           storeBe;
  logic [7:0]           ldByte;
  logic [15:0]          ldHalf;

  // Store data is replicated so the lane picked by the byte enables carries it.
  genvar gi;
  generate
    for (gi = 0; gi < XLEN / 8; gi++) begin : gLane
      assign storeWData[gi*8 +: 8] = (iMemOpType[1:0] == 2'b00) ? iMemData[7:0] :
                                     (iMemOpType[1:0] == 2'b01) ? iMemData[(gi % 2)*8 +: 8] :
                                                                  iMemData[gi*8 +: 8];
    end
  endgenerate

  always_comb begin
    accept  = iMemValid && (stateReg == IDLE) && (iMemRead || iMemWrite);
    opLegal = iMemRead ? (iMemOpType inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})
                       : (iMemOpType inside {3'b000, 3'b001, 3'b010});
    misaligned = ((iMemOpType[1:0] == 2'b01) && iMemAddr[0]) ||
                 ((iMemOpType[1:0] == 2'b10) && (iMemAddr[1:0] != 2'b00));
    case (iMemOpType[1:0])
      2'b00:   storeBe = 4'b0001 << iMemAddr[1:0];
      2'b01:   storeBe = 4'b0011 << iMemAddr[1:0];
      default: storeBe = 4'b1111;
    endcase
    cntInc     = {1'b0, cntReg} + {{CNT_W{1'b0}}, 1'b1};
    timeoutHit = (ACK_TIMEOUT != 0) && (int'(cntInc) == ACK_TIMEOUT);
  end

  always_comb begin
    ldByte = iBusRData[{addrReg[1:0], 3'b000} +: 8];
    ldHalf = addrReg[1] ? iBusRData[31:16] : iBusRData[15:0];
    case (opReg)
      3'b000:  loadExt = {{24{ldByte[7]}}, ldByte};
      3'b001:  loadExt = {{16{ldHalf[15]}}, ldHalf};
      3'b100:  loadExt = {24'd0, ldByte};
      3'b101:  loadExt = {16'd0, ldHalf};
      default: loadExt = iBusRData;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      stateReg    <= IDLE;
      cntReg      <= '0;
      addrReg     <= '0;
      opReg       <= '0;
      rdReg       <= '0;
      busReqReg   <= 1'b0;
      busWeReg    <= 1'b0;
      busAddrReg  <= '0;
      busWDataReg <= '0;
      busBeReg    <= '0;
      regDvReg    <= 1'b0;
      regAddrReg  <= '0;
      regDataReg  <= '0;
      excDvReg    <= 1'b0;
      excCauseReg <= 2'b00;
      excAddrReg  <= '0;
    end else begin
      regDvReg <= 1'b0;
      excDvReg <= 1'b0;
      case (stateReg)
        IDLE: if (accept) begin
          if (!opLegal || misaligned) begin
            // Illegal funct3 outranks misalignment; the operation never reaches the bus.
            excDvReg    <= 1'b1;
            excCauseReg <= !opLegal ? 2'b10 : 2'b01;
            excAddrReg  <= iMemAddr;
          end else begin
            stateReg    <= BUS;
            cntReg      <= '0;
            addrReg     <= iMemAddr;
            opReg       <= iMemOpType;
            rdReg       <= iMemRdAddr;
            busReqReg   <= 1'b1;
            busWeReg    <= !iMemRead;
            busAddrReg  <= {iMemAddr[XLEN-1:2], 2'b00};
            busWDataReg <= iMemRead ? '0 : storeWData;
            busBeReg    <= iMemRead ? 4'b1111 : storeBe;
          end
        end
        BUS: begin
          if (iBusAck) begin
            busReqReg <= 1'b0;
            if (busWeReg) begin
              stateReg <= IDLE;
            end else begin
              stateReg   <= WB;
              regDvReg   <= (rdReg != '0);
              regAddrReg <= rdReg;
              regDataReg <= loadExt;
            end
          end else if (timeoutHit) begin
            busReqReg   <= 1'b0;
            stateReg    <= IDLE;
            excDvReg    <= 1'b1;
            excCauseReg <= 2'b11;
            excAddrReg  <= addrReg;
          end else begin
            cntReg <= cntInc[CNT_W-1:0];
          end
        end
        default: stateReg <= IDLE;
      endcase
    end
  end

  assign oReady    = (stateReg == IDLE);
  assign oBusReq   = busReqReg;
  assign oBusWe    = busWeReg;
  assign oBusAddr  = busAddrReg;
  assign oBusWData = busWDataReg;
  assign oBusBe    = busBeReg;
  assign oRegDv    = regDvReg;
  assign oRegAddr  = regAddrReg;
  assign oRegData  = regDataReg;
  assign oExcDv    = excDvReg;
  assign oExcCause = excCauseReg;
  assign oExcAddr  = excAddrReg;

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Sits directly downstream of the execute stage's load/store path. Consumes one decoded memory operation per transaction: address, store data, funct3, read/write flags and destination register.
- Runs a request/acknowledge transaction on the data-memory bus. For stores it generates byte lanes; for loads it extracts and sign- or zero-extends the result, then emits a register-writeback record.
- Detects misaligned accesses, illegal funct3 and bus timeout, and reports them as a one-cycle exception pulse.

Parameters:
- XLEN, 32, data/address width. Only 32 is supported; any other value is an elaboration error.
- REG_SEL_W, 5, register-address width.
- ACK_TIMEOUT, 255, maximum bus cycles to wait for iBusAck. 0 disables the timeout.

Ports:
- iClk  in  1  clock; all state updates on rising edge
- iRst  in  1  synchronous reset, active-high
- iMemValid  in  1  memory operation present
- iMemRead  in  1  load
- iMemWrite  in  1  store
- iMemAddr  in  XLEN  effective byte address
- iMemData  in  XLEN  store data (rs2)
- iMemOpType  in  3  funct3
- iMemRdAddr  in  REG_SEL_W  load destination
- oReady  out  1  stage can accept an operation this cycle
- oBusReq  out  1  bus request
- oBusWe  out  1  1 = write
- oBusAddr  out  XLEN  word-aligned address, bits [1:0] = 0
- oBusWData  out  XLEN  lane-replicated write data
- oBusBe  out  XLEN/8  byte enables
- iBusAck  in  1  transaction complete
- iBusRData  in  XLEN  read data, valid when iBusAck = 1
- oRegDv  out  1  writeback valid, one-cycle pulse
- oRegAddr  out  REG_SEL_W  writeback register
- oRegData  out  XLEN  writeback data
- oExcDv  out  1  exception pulse
- oExcCause  out  2  01 misaligned, 10 illegal funct3, 11 bus timeout
- oExcAddr  out  XLEN  faulting byte address

Behaviour:
- Reset: every output is 0 except oReady = 1. FSM goes to IDLE and the timeout counter clears.
- Reset mid-transaction: oBusReq drops in the cycle after reset is sampled. No writeback and no exception are produced for the abandoned operation.
- FSM states are IDLE, BUS and WB. oReady = 1 only in IDLE.
- Accept: iMemValid & oReady & (iMemRead | iMemWrite) at an edge.
  - iMemRead has priority if both flags are set.
  - Valid with neither flag set is ignored.
- Legal loads: funct3 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- Legal stores: funct3 000 SB, 001 SH, 010 SW.
- Any other funct3 on accept:
  - oExcDv = 1 next cycle, cause 10, oExcAddr = iMemAddr.
  - No bus request; FSM stays IDLE.
- Misaligned on accept (halfword with addr[0] = 1, word with addr[1:0] ≠ 0):
  - cause 01, same timing as above, no bus request.
  - Illegal funct3 takes priority over misalignment.
- Legal aligned accept at edge N:
  - FSM enters BUS; oBusReq = 1 from cycle N+1.
  - oBusAddr = {addr[31:2], 00} and oBusWe = write.
  - Address, data and byte enables stay stable until iBusAck is sampled.
  - Counter clears.
- Store lanes:
  - SB: oBusBe = 0001 << addr[1:0], oBusWData = {4{data[7:0]}}.
  - SH: oBusBe = 0011 << addr[1:0], oBusWData = {2{data[15:0]}}.
  - SW: oBusBe = 1111, oBusWData = data.
  - Loads drive oBusBe = 1111 and oBusWData = 0.
- BUS with iBusAck = 1 at an edge:
  - oBusReq = 0 next cycle.
  - Store: return to IDLE.
  - Load: capture iBusRData and go to WB.
- iBusAck outside BUS is ignored.
- WB: oRegDv = 1 for exactly one cycle, then IDLE.
  - oRegAddr = captured rd.
  - oRegData = lane selected by addr[1:0] (byte) or addr[1] (half), sign-extended for LB/LH and zero-extended for LBU/LHU.
  - If rd = 0, oRegDv stays 0; the bus read still occurs.
- Load latency: accept N, ack in cycle N+1, oRegDv in cycle N+2. Each extra wait cycle adds one cycle.
- Throughput: the next accept is possible in the cycle oReady returns to 1.
- Timeout (ACK_TIMEOUT > 0):
  - The counter increments on each BUS cycle without ack.
  - When the count equals ACK_TIMEOUT and ack is 0: drop oBusReq, pulse oExcDv with cause 11, return to IDLE, no writeback.
  - Ack arriving on that same cycle wins and the transaction completes normally.
- oExcDv and oRegDv are never high in the same cycle.

Test Plan:
- SW addr 0x100, data 0xDEADBEEF, ack on first request cycle -> oBusReq for 1 cycle, oBusAddr 0x100, oBusBe 1111, oBusWData 0xDEADBEEF, oRegDv stays 0, oReady back after 2 cycles.
- SB addr 0x103, data 0x000000A5 -> oBusBe 1000, oBusWData 0xA5A5A5A5; SH addr 0x202, data 0x1234 -> oBusBe 1100, oBusWData 0x12341234.
- LB addr 0x101, rd 7, iBusRData 0x0000_8000, ack after 3 wait cycles -> oRegDv on the cycle after ack, oRegData 0xFFFFFF80, oRegAddr 7. Same access as LBU -> oRegData 0x00000080.
- LH addr 0x201 -> oExcDv, cause 01, oExcAddr 0x201, no oBusReq. funct3 011 load -> cause 10.
- ACK_TIMEOUT = 4, no ack -> oBusReq high 4 cycles, then oExcDv with cause 11. Repeat with ack on cycle 4 -> normal completion, no exception.
- iRst asserted during BUS of a load -> oBusReq 0 next cycle, no oRegDv, oReady = 1. LW rd 0 -> bus read issued, oRegDv stays 0.
